multicycle_controller: RTL and testbench

- Control unit for a 16-bit multicycle processor with an IITB-RISC-style ISA: opcode = instr[15:12], condition field cz = instr[1:0].
- A Moore FSM sequences fetch, decode, execute, memory and writeback.
- It drives the datapath's mux selects, write enables and ALU operation.
- The datapath supplies op, cz and the zero flag.

---
 rtl/multicycle_pkg.sv | 39 +++
 rtl/multicycle_controller_alu_decoder.sv | 11 +
 rtl/multicycle_controller.sv | 100 ++++++++++
 tb/tb_multicycle_controller.sv | 127 ++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared state, opcode, ALU and select encodings for the multicycle controller.
package multicycle_pkg;
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_RTYPEEX = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_ADIEX   = 4'd8;
    localparam state_t S_ADIWB   = 4'd9;
    localparam state_t S_BEQEX   = 4'd10;
    localparam state_t S_JEX     = 4'd11;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_J    = 4'b1001;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_NAND = 3'b100;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [1:0] {ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_RTYPE} alu_cls_e;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: selects the ALU operation from the state class and, for R-type execute, the opcode.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [3:0] op,
    input  alu_cls_e   cls,
    output logic [2:0] alucontrol
);
    always_comb alucontrol = (cls == ALU_CLS_SUB) ? ALU_SUB :
                             (cls == ALU_CLS_RTYPE && op == OP_NAND) ? ALU_NAND : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/writeback for a 16-bit multicycle CPU.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [1:0] cz,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);
    state_t   state_q, state_d;
    alu_cls_e cls;

    always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:
                case (op)
                    OP_ADD, OP_NAND: state_d = S_RTYPEEX;
                    OP_ADI:          state_d = S_ADIEX;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:          state_d = S_BEQEX;
                    OP_J:            state_d = S_JEX;
                    default:         state_d = S_FETCH;
                endcase
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ADIEX:   state_d = S_ADIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (.op(op), .cls(cls), .alucontrol(alucontrol));

    always_comb begin
        {pcen, memwrite, irwrite, regwrite} = '0;
        {alusrca, iord, memtoreg, regdst} = '0;
        alusrcb = SRCB_REGB;
        pcsrc = PC_ALU;
        cls = ALU_CLS_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb = SRCB_ONE;
                irwrite = 1'b1;
                pcen = 1'b1;
            end
            S_DECODE:  alusrcb = SRCB_BR;
            S_MEMADR, S_ADIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                cls = ALU_CLS_RTYPE;
            end
            // Zero-conditional forms (cz=01) suppress the write when the stored flag is clear
            S_ALUWB: begin
                regdst = 1'b1;
                regwrite = !(cz == 2'b01 && !zero);
            end
            S_ADIWB:   regwrite = 1'b1;
            S_BEQEX: begin
                alusrca = 1'b1;
                cls = ALU_CLS_SUB;
                pcsrc = PC_ALUOUT;
                pcen = zero;
            end
            S_JEX: begin
                pcsrc = PC_JUMP;
                pcen = 1'b1;
            end
            default: ;
        endcase
        if (reset) {pcen, memwrite, irwrite, regwrite} = '0;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle stimulus with a queued scoreboard of expected control vectors.
module tb_multicycle_controller;
    logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [3:0] op = 4'b0000;
    logic [1:0] cz = 2'b00;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [14:0] act;

    typedef struct {string name; logic [14:0] v;} exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .cz(cz), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
    );

    assign act = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol};

    function automatic logic [14:0] v(input logic pc, mw, ir, rw, a, io, m2r, rd,
                                      input logic [1:0] b, s, input logic [2:0] al);
        return {pc, mw, ir, rw, a, io, m2r, rd, b, s, al};
    endfunction

    logic [14:0] V_RST, V_FETCH, V_DEC, V_RT_ADD, V_RT_NAND, V_WB_W, V_WB_N, V_MADR, V_MRD, V_MWB,
                 V_MWR, V_ADIEX, V_ADIWB, V_BEQ_T, V_BEQ_N, V_BEQ_RST, V_JEX;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (act === e.v) passed++;
            else $display("FAIL %s: got %015b want %015b", e.name, act, e.v);
        end
    end

    task automatic step(input string name, input logic r, input logic [3:0] o, input logic [1:0] c,
                        input logic z, input logic [14:0] e);
        @(posedge clk);
        #1;
        reset = r; op = o; cz = c; zero = z;
        sb.push_back('{name, e});
    endtask

    task automatic fd(input string name, input logic [3:0] o, input logic [1:0] c, input logic z);
        step({name, "_fetch"}, 1'b0, o, c, z, V_FETCH);
        step({name, "_decode"}, 1'b0, o, c, z, V_DEC);
    endtask

    initial begin
        //             pc mw ir rw a io m2r rd  srcb   pcsrc  alu
        V_RST     = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        V_FETCH   = v(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        V_DEC     = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
        V_RT_ADD  = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010);
        V_RT_NAND = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b100);
        V_WB_W    = v(0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010);
        V_WB_N    = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010);
        V_MADR    = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010);
        V_MRD     = v(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010);
        V_MWB     = v(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010);
        V_MWR     = v(0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010);
        V_ADIEX   = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010);
        V_ADIWB   = v(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
        V_BEQ_T   = v(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110);
        V_BEQ_N   = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110);
        V_BEQ_RST = v(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110);
        V_JEX     = v(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);
        repeat (2) @(posedge clk);
        step("rst_hold", 1'b1, 4'b0000, 2'b00, 1'b0, V_RST);
        fd("add", 4'b0000, 2'b00, 1'b0);
        step("add_rtex", 1'b0, 4'b0000, 2'b00, 1'b0, V_RT_ADD);
        step("add_aluwb", 1'b0, 4'b0000, 2'b00, 1'b0, V_WB_W);
        fd("adc", 4'b0000, 2'b10, 1'b0);
        step("adc_rtex", 1'b0, 4'b0000, 2'b10, 1'b0, V_RT_ADD);
        step("adc_aluwb", 1'b0, 4'b0000, 2'b10, 1'b0, V_WB_W);
        fd("ndu", 4'b0010, 2'b00, 1'b0);
        step("ndu_rtex", 1'b0, 4'b0010, 2'b00, 1'b0, V_RT_NAND);
        step("ndu_aluwb", 1'b0, 4'b0010, 2'b00, 1'b0, V_WB_W);
        fd("ndz0", 4'b0010, 2'b01, 1'b0);
        step("ndz0_rtex", 1'b0, 4'b0010, 2'b01, 1'b0, V_RT_NAND);
        step("ndz0_aluwb", 1'b0, 4'b0010, 2'b01, 1'b0, V_WB_N);
        fd("ndz1", 4'b0010, 2'b01, 1'b1);
        step("ndz1_rtex", 1'b0, 4'b0010, 2'b01, 1'b1, V_RT_NAND);
        step("ndz1_aluwb", 1'b0, 4'b0010, 2'b01, 1'b1, V_WB_W);
        fd("lw", 4'b0100, 2'b00, 1'b0);
        step("lw_memadr", 1'b0, 4'b0100, 2'b00, 1'b0, V_MADR);
        step("lw_memrd", 1'b0, 4'b0100, 2'b00, 1'b0, V_MRD);
        step("lw_memwb", 1'b0, 4'b0100, 2'b00, 1'b0, V_MWB);
        fd("sw", 4'b0101, 2'b00, 1'b0);
        step("sw_memadr", 1'b0, 4'b0101, 2'b00, 1'b0, V_MADR);
        step("sw_memwr", 1'b0, 4'b0101, 2'b00, 1'b0, V_MWR);
        fd("adi", 4'b0001, 2'b00, 1'b0);
        step("adi_ex", 1'b0, 4'b0001, 2'b00, 1'b0, V_ADIEX);
        step("adi_wb", 1'b0, 4'b0001, 2'b00, 1'b0, V_ADIWB);
        fd("beq1", 4'b1100, 2'b00, 1'b1);
        step("beq1_ex", 1'b0, 4'b1100, 2'b00, 1'b1, V_BEQ_T);
        fd("beq0", 4'b1100, 2'b00, 1'b0);
        step("beq0_ex", 1'b0, 4'b1100, 2'b00, 1'b0, V_BEQ_N);
        fd("j", 4'b1001, 2'b00, 1'b0);
        step("j_ex", 1'b0, 4'b1001, 2'b00, 1'b0, V_JEX);
        fd("nop", 4'b1111, 2'b00, 1'b0);
        fd("beqrst", 4'b1100, 2'b00, 1'b1);
        step("beqrst_ex", 1'b1, 4'b1100, 2'b00, 1'b1, V_BEQ_RST);
        fd("post_rst", 4'b0000, 2'b00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
